// File: rtl/rd_return_receiver_if.sv
// Read-return bus between the memory controller / core issue logic and the
// per-core return receiver. The receiver side uses the slave modport.
interface rd_return_receiver_if #(
    parameter int LINE_AW   = 23,
    parameter int PEND_LOG2 = 2
);
    logic [3:0]           whoami;
    logic [31:0]          RDreturn;
    logic [3:0]           RDdest;
    logic                 reqValid;
    logic [LINE_AW-1:0]   reqLine;
    logic                 reqReady;
    logic                 fillWr;
    logic [LINE_AW+2:0]   fillAddr;
    logic [31:0]          fillData;
    logic                 lineDone;
    logic [LINE_AW-1:0]   doneLine;
    logic [PEND_LOG2:0]   pendCount;
    logic                 protoErr;

    modport master (
        output whoami, RDreturn, RDdest, reqValid, reqLine,
        input  reqReady, fillWr, fillAddr, fillData, lineDone, doneLine,
               pendCount, protoErr
    );

    modport slave (
        input  whoami, RDreturn, RDdest, reqValid, reqLine,
        output reqReady, fillWr, fillAddr, fillData, lineDone, doneLine,
               pendCount, protoErr
    );
endinterface

// File: rtl/rd_return_receiver.sv
// Per-core read-return receiver: keeps an in-order FIFO of outstanding line
// reads, turns the 8 returned words of each line into registered cache fill
// writes, pulses lineDone on the last word and flags returns with nothing
// outstanding.
module rd_return_receiver #(
    parameter int LINE_AW   = 23,
    parameter int PEND_LOG2 = 2
) (
    input  logic              clock,
    input  logic              reset,
    rd_return_receiver_if.slave bus
);
    localparam int DEPTH = 1 << PEND_LOG2;
    localparam logic [PEND_LOG2:0] FULL = (PEND_LOG2+1)'(DEPTH);

    logic [LINE_AW-1:0]   pend_mem [DEPTH];
    logic [PEND_LOG2-1:0] head;
    logic [PEND_LOG2-1:0] tail;
    logic [PEND_LOG2:0]   count;
    logic [2:0]           word_cnt;
    logic                 hit;
    logic                 non_empty;
    logic                 ready;
    logic                 push;
    logic                 fill;
    logic                 pop;
    logic [LINE_AW-1:0]   head_line;

    // ID 0 means idle on the return path, so a core with ID 0 never matches.
    assign hit       = (bus.RDdest == bus.whoami) && (bus.whoami != 4'd0);
    assign non_empty = (count != '0);
    // Ready is judged on the pre-pop count: a slot freed this cycle is not
    // usable until the next one.
    assign ready     = (count != FULL);
    assign push      = bus.reqValid && ready;
    assign fill      = hit && non_empty;
    assign pop       = fill && (word_cnt == 3'd7);
    assign head_line = pend_mem[head];

    assign bus.reqReady  = ready;
    assign bus.pendCount = count;

    // Line-address storage; only the pointers need a reset value.
    always_ff @(posedge clock) begin
        if (push) pend_mem[tail] <= bus.reqLine;
    end

    // FIFO bookkeeping, word counter, and the registered fill/done outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            word_cnt     <= 3'd0;
            bus.fillWr   <= 1'b0;
            bus.fillAddr <= '0;
            bus.fillData <= '0;
            bus.lineDone <= 1'b0;
            bus.doneLine <= '0;
            bus.protoErr <= 1'b0;
        end else begin
            if (push) tail <= tail + PEND_LOG2'(1);
            if (pop)  head <= head + PEND_LOG2'(1);
            case ({push, pop})
                2'b10:   count <= count + (PEND_LOG2+1)'(1);
                2'b01:   count <= count - (PEND_LOG2+1)'(1);
                default: count <= count;
            endcase
            // Word index only advances on accepted words, so idle gaps and
            // stray returns leave the position within the line untouched.
            if (fill) word_cnt <= word_cnt + 3'd1;
            if (hit && !non_empty) bus.protoErr <= 1'b1;
            bus.fillWr   <= fill;
            bus.lineDone <= pop;
            if (fill) begin
                bus.fillAddr <= {head_line, word_cnt};
                bus.fillData <= bus.RDreturn;
            end
            if (pop) bus.doneLine <= head_line;
        end
    end
endmodule

// File: tb/tb_rd_return_receiver.sv
// Randomized bench for rd_return_receiver against a queue-based model of the
// outstanding reads and the position within the current line.
module tb_rd_return_receiver;
    localparam int LINE_AW   = 23;
    localparam int PEND_LOG2 = 2;
    localparam int DEPTH     = 1 << PEND_LOG2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    rd_return_receiver_if #(.LINE_AW(LINE_AW), .PEND_LOG2(PEND_LOG2)) bus ();

    rd_return_receiver #(.LINE_AW(LINE_AW), .PEND_LOG2(PEND_LOG2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [LINE_AW-1:0]  q[$];
    int                  wi = 0;
    logic                m_fillWr = 0;
    logic [LINE_AW+2:0]  m_fillAddr = '0;
    logic [31:0]         m_fillData = '0;
    logic                m_lineDone = 0;
    logic [LINE_AW-1:0]  m_doneLine = '0;
    logic                m_protoErr = 0;
    int                  obs_fill = 0;
    int                  obs_done = 0;

    task automatic idle_inputs();
        bus.RDdest   = 4'd0;
        bus.RDreturn = $urandom;
        bus.reqValid = 1'b0;
        bus.reqLine  = '0;
    endtask

    // One clock: advance the model on the current inputs, clock, compare.
    task automatic tick();
        logic hit;
        logic rdy;
        hit = (bus.RDdest == bus.whoami) && (bus.whoami != 4'd0);
        rdy = (q.size() < DEPTH);
        checks++;
        if (bus.reqReady !== rdy) begin
            failures++;
            $display("FAIL reqReady got=%0b want=%0b t=%0t", bus.reqReady, rdy, $time);
        end
        m_fillWr = 0;
        m_lineDone = 0;
        if (hit && q.size() == 0) m_protoErr = 1;
        if (hit && q.size() > 0) begin
            m_fillWr   = 1;
            m_fillAddr = {q[0], 3'(wi)};
            m_fillData = bus.RDreturn;
            if (wi == 7) begin
                m_lineDone = 1;
                m_doneLine = q[0];
                void'(q.pop_front());
                wi = 0;
            end else begin
                wi++;
            end
        end
        if (bus.reqValid && rdy) q.push_back(bus.reqLine);
        @(posedge clock);
        #1;
        obs_fill += int'(bus.fillWr);
        obs_done += int'(bus.lineDone);
        checks++;
        if (bus.fillWr !== m_fillWr || bus.lineDone !== m_lineDone ||
            bus.doneLine !== m_doneLine || bus.protoErr !== m_protoErr ||
            bus.pendCount !== 3'(q.size())) begin
            failures++;
            $display("FAIL outputs got wr=%0b done=%0b dl=%h err=%0b cnt=%0d want wr=%0b done=%0b dl=%h err=%0b cnt=%0d t=%0t",
                     bus.fillWr, bus.lineDone, bus.doneLine, bus.protoErr, bus.pendCount,
                     m_fillWr, m_lineDone, m_doneLine, m_protoErr, q.size(), $time);
        end
        if (m_fillWr) begin
            checks++;
            if (bus.fillAddr !== m_fillAddr || bus.fillData !== m_fillData) begin
                failures++;
                $display("FAIL fill got addr=%h data=%h want addr=%h data=%h t=%0t",
                         bus.fillAddr, bus.fillData, m_fillAddr, m_fillData, $time);
            end
        end
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        #3;
        q.delete();
        wi = 0;
        m_fillWr = 0; m_fillAddr = '0; m_fillData = '0;
        m_lineDone = 0; m_doneLine = '0; m_protoErr = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic push_line(input logic [LINE_AW-1:0] line);
        idle_inputs();
        bus.reqValid = 1'b1;
        bus.reqLine  = line;
        tick();
        bus.reqValid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] data);
        idle_inputs();
        bus.RDdest   = bus.whoami;
        bus.RDreturn = data;
        tick();
    endtask

    task automatic test_reset();
        bus.whoami = 4'd3;
        apply_reset();
        checks++;
        if (bus.fillWr !== 0 || bus.fillAddr !== '0 || bus.fillData !== '0 ||
            bus.lineDone !== 0 || bus.doneLine !== '0 || bus.pendCount !== '0 ||
            bus.protoErr !== 0 || bus.reqReady !== 1) begin
            failures++;
            $display("FAIL reset_state got wr=%0b addr=%h data=%h done=%0b dl=%h cnt=%0d err=%0b rdy=%0b want all zero rdy=1",
                     bus.fillWr, bus.fillAddr, bus.fillData, bus.lineDone,
                     bus.doneLine, bus.pendCount, bus.protoErr, bus.reqReady);
        end
    endtask

    task automatic test_single_line();
        bus.whoami = 4'd3;
        obs_fill = 0; obs_done = 0;
        push_line(23'h12345);
        checks++;
        if (bus.pendCount !== 3'd1) begin
            failures++;
            $display("FAIL single_cnt1 got=%0d want=1", bus.pendCount);
        end
        for (int i = 0; i < 8; i++) send_word(32'hA0 + 32'(i));
        idle_inputs();
        tick();
        checks++;
        if (obs_fill != 8 || obs_done != 1 || bus.doneLine !== 23'h12345 || bus.pendCount !== 3'd0) begin
            failures++;
            $display("FAIL single_line got fills=%0d dones=%0d dl=%h cnt=%0d want 8 1 12345 0",
                     obs_fill, obs_done, bus.doneLine, bus.pendCount);
        end
    endtask

    task automatic test_interleaved();
        int hits;
        bus.whoami = 4'd5;
        obs_fill = 0; obs_done = 0;
        push_line(23'h10);
        push_line(23'h20);
        hits = 0;
        for (int c = 0; c < 200 && hits < 16; c++) begin
            idle_inputs();
            case ($urandom_range(0, 2))
                0: bus.RDdest = 4'd5;
                1: bus.RDdest = 4'd0;
                default: bus.RDdest = 4'($urandom_range(6, 15));
            endcase
            if (bus.RDdest == 4'd5) hits++;
            tick();
        end
        idle_inputs();
        tick();
        checks++;
        if (hits != 16 || obs_fill != 16 || obs_done != 2 || bus.doneLine !== 23'h20) begin
            failures++;
            $display("FAIL interleaved got hits=%0d fills=%0d dones=%0d dl=%h want 16 16 2 20",
                     hits, obs_fill, obs_done, bus.doneLine);
        end
    endtask

    task automatic test_full();
        logic [LINE_AW-1:0] extra;
        bus.whoami = 4'd7;
        obs_done = 0;
        for (int i = 0; i < DEPTH; i++) push_line(LINE_AW'($urandom));
        checks++;
        if (bus.reqReady !== 1'b0 || bus.pendCount !== 3'd4) begin
            failures++;
            $display("FAIL full got rdy=%0b cnt=%0d want 0 4", bus.reqReady, bus.pendCount);
        end
        push_line(23'h7FFFF);
        checks++;
        if (bus.pendCount !== 3'd4) begin
            failures++;
            $display("FAIL full_ignore got cnt=%0d want 4", bus.pendCount);
        end
        for (int i = 0; i < 7; i++) send_word($urandom);
        extra = LINE_AW'($urandom);
        idle_inputs();
        bus.RDdest   = bus.whoami;
        bus.RDreturn = $urandom;
        bus.reqValid = 1'b1;
        bus.reqLine  = extra;
        tick();
        checks++;
        if (bus.pendCount !== 3'd3 || bus.lineDone !== 1'b1) begin
            failures++;
            $display("FAIL full_pop_nopush got cnt=%0d done=%0b want 3 1", bus.pendCount, bus.lineDone);
        end
        push_line(extra);
        checks++;
        if (bus.pendCount !== 3'd4) begin
            failures++;
            $display("FAIL full_repush got cnt=%0d want 4", bus.pendCount);
        end
        for (int i = 0; i < 32; i++) send_word($urandom);
        checks++;
        if (bus.doneLine !== extra || bus.pendCount !== 3'd0 || obs_done != 5) begin
            failures++;
            $display("FAIL full_order got dl=%h cnt=%0d dones=%0d want %h 0 5",
                     bus.doneLine, bus.pendCount, obs_done, extra);
        end
    endtask

    task automatic test_proto_err();
        bus.whoami = 4'd9;
        apply_reset();
        send_word(32'hDEAD);
        checks++;
        if (bus.protoErr !== 1'b1 || bus.fillWr !== 1'b0) begin
            failures++;
            $display("FAIL proto_set got err=%0b wr=%0b want 1 0", bus.protoErr, bus.fillWr);
        end
        obs_fill = 0;
        push_line(23'h4321);
        for (int i = 0; i < 8; i++) send_word($urandom);
        checks++;
        if (bus.protoErr !== 1'b1 || obs_fill != 8 || bus.fillAddr !== {23'h4321, 3'd7}) begin
            failures++;
            $display("FAIL proto_sticky got err=%0b fills=%0d addr=%h want 1 8 %h",
                     bus.protoErr, obs_fill, bus.fillAddr, {23'h4321, 3'd7});
        end
    endtask

    task automatic test_reset_mid();
        bus.whoami = 4'd2;
        push_line(23'h111);
        push_line(23'h222);
        for (int i = 0; i < 3; i++) send_word($urandom);
        apply_reset();
        checks++;
        if (bus.pendCount !== '0 || bus.protoErr !== 0 || bus.doneLine !== '0 ||
            bus.fillAddr !== '0 || bus.reqReady !== 1) begin
            failures++;
            $display("FAIL reset_mid got cnt=%0d err=%0b dl=%h addr=%h rdy=%0b want 0 0 0 0 1",
                     bus.pendCount, bus.protoErr, bus.doneLine, bus.fillAddr, bus.reqReady);
        end
        obs_done = 0;
        push_line(23'h333);
        send_word(32'h55);
        checks++;
        if (bus.fillAddr !== {23'h333, 3'd0}) begin
            failures++;
            $display("FAIL reset_mid_word0 got addr=%h want %h", bus.fillAddr, {23'h333, 3'd0});
        end
        for (int i = 1; i < 8; i++) send_word($urandom);
        idle_inputs();
        tick();
        checks++;
        if (obs_done != 1 || bus.doneLine !== 23'h333) begin
            failures++;
            $display("FAIL reset_mid_done got dones=%0d dl=%h want 1 333", obs_done, bus.doneLine);
        end
    endtask

    task automatic test_whoami_zero();
        bus.whoami = 4'd0;
        apply_reset();
        push_line(23'h99);
        obs_fill = 0;
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            tick();
        end
        checks++;
        if (obs_fill != 0 || bus.protoErr !== 1'b0 || bus.pendCount !== 3'd1) begin
            failures++;
            $display("FAIL whoami_zero got fills=%0d err=%0b cnt=%0d want 0 0 1",
                     obs_fill, bus.protoErr, bus.pendCount);
        end
    endtask

    initial begin
        bus.whoami = 4'd3;
        idle_inputs();
        test_reset();
        test_single_line();
        test_interleaved();
        test_full();
        test_proto_err();
        test_reset_mid();
        test_whoami_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rd_return_receiver.md
Name: rd_return_receiver

Overview:
Per-core consumer of the memory controller's dedicated read-return path (RDreturn/RDdest).
- Tracks the core's outstanding line reads in an in-order pending FIFO.
- Captures the 8 words of each returned cache line addressed to this core and presents them as registered fill writes to the core's cache.
- Pulses line-complete when the last word is written.
- Flags returns that arrive with nothing outstanding.

Parameters:
LINE_AW, 23, width of a cache-line address (word address bits [LINE_AW+2:3])
PEND_LOG2, 2, log2 of pending-FIFO depth (default depth 4)

Ports:
clock  in  1  system clock; all state updates on posedge
reset  in  1  asynchronous, active-high; clears all state
whoami  in  4  this core's ring ID; 0 is illegal (RDdest 0 means idle)
RDreturn  in  32  read data word from memory controller
RDdest  in  4  destination core of RDreturn; 0 = no data this cycle
reqValid  in  1  core issued a read Address slot for line reqLine this cycle
reqLine  in  LINE_AW  line address of issued read
reqReady  out  1  pending FIFO not full; core must not issue a read while low
fillWr  out  1  write strobe to cache data array
fillAddr  out  LINE_AW+3  {line, word index}
fillData  out  32  word to write
lineDone  out  1  one-cycle pulse with the 8th fillWr of a line
doneLine  out  LINE_AW  line address accompanying lineDone
pendCount  out  PEND_LOG2+1  outstanding line reads
protoErr  out  1  sticky: return word seen with FIFO empty

Behaviour:
- Reset values: fillWr=0, fillAddr=0, fillData=0, lineDone=0, doneLine=0, pendCount=0, protoErr=0, reqReady=1, wordCnt=0, FIFO pointers=0.
- Match: hit = (RDdest == whoami) & (whoami != 0). With whoami = 0, hit never asserts.
- Pending FIFO: circular buffer of PEND_LOG2 pointers plus a count register.
  - Push on reqValid & reqReady.
  - reqValid while full is ignored; no state change.
  - reqReady = (pendCount != 2^PEND_LOG2), combinational from count.
- wordCnt: 3-bit, increments on hit & FIFO non-empty, wraps 7->0.
- Pop: on hit & (wordCnt == 7) & non-empty.
- Simultaneous push and pop: count unchanged, both pointers advance. Push is permitted in the same cycle the FIFO goes from full to not-full only if reqReady was already high, because reqReady is evaluated before the pop.
- Fill output, registered with latency 1 cycle from the hit cycle:
  - fillWr = hit & non-empty.
  - fillAddr = {head line, wordCnt}.
  - fillData = RDreturn.
- lineDone: registered with fillWr when wordCnt was 7. doneLine = head line at that hit; it holds until the next lineDone.
- Gaps between matching words: any number of idle or other-core cycles is allowed between words of a line; wordCnt holds across them.
- Word order: words arrive in address order 0..7. Per-core returns are in issue order because the controller returns reads FIFO-order.
- Return with FIFO empty (hit & count == 0):
  - Data is dropped; fillWr stays 0.
  - wordCnt is unchanged.
  - protoErr sets and stays set until reset.
- Reset mid-line: partial line and all pending entries are discarded. Post-reset, the first hit is treated as word 0 of the next pushed line.
- pendCount wraps never: push is gated by reqReady, pop by non-empty.

Test Plan:
1. whoami=3; push line 0x12345; drive RDdest=3, RDreturn=0xA0..0xA7 on 8 consecutive cycles -> fillWr asserts for 8 cycles, one cycle late, with fillAddr={0x12345,0..7} and matching data. lineDone pulses with the word-7 write; doneLine=0x12345; pendCount goes 1->0.
2. Push lines 0x10 and 0x20; return 16 words with RDdest=5/0 interleaved irregularly -> first 8 hits written to line 0x10, next 8 to 0x20. Two lineDone pulses; non-matching cycles cause no fillWr.
3. Push 4 lines (depth 4) -> reqReady=0 and pendCount=4. A 5th reqValid is ignored. In the cycle the first line's word 7 arrives, drive reqValid with a new line -> FIFO not pushed that cycle. Next cycle reqReady=1 and the push is accepted; final order is preserved.
4. Empty FIFO; drive RDdest=whoami for 1 cycle -> no fillWr, protoErr=1 and sticky. Then push a line and return 8 words -> normal fill with word index starting at 0.
5. Push 2 lines, return 3 words, assert reset for 1 cycle -> all outputs at reset values. Then push a line and return 8 words -> fillAddr indices 0..7 on the new line; lineDone once.
6. whoami=0; drive RDdest=0 with random RDreturn -> no fillWr, no protoErr.
